// File: rtl/icache_refill_ctrl_pkg.sv
// Shared I-cache definitions: geometry, FSM state encoding, one-hot way constants.
// Used by icache_refill_ctrl, its interface and the victim LFSR.
package icache_refill_ctrl_pkg;

    localparam int WAYS       = 4;
    localparam int LINE_W     = 512;
    localparam int BEAT_W     = 32;
    localparam int INDEX_W    = 6;
    localparam int BEATS      = LINE_W / BEAT_W;
    localparam int BEAT_CNT_W = $clog2(BEATS);
    localparam int OFFSET_W   = 6;
    localparam int INDEX_LSB  = OFFSET_W;
    localparam int INDEX_MSB  = OFFSET_W + INDEX_W - 1;

    localparam logic [WAYS-1:0] HIT0 = 4'b0001;
    localparam logic [WAYS-1:0] HIT1 = 4'b0010;
    localparam logic [WAYS-1:0] HIT2 = 4'b0100;
    localparam logic [WAYS-1:0] HIT3 = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOOKUP = 3'd1,
        S_MISS   = 3'd2,
        S_REFILL = 3'd3,
        S_FILL   = 3'd4
    } state_t;

    // Keeps only the lowest set bit, so a malformed multi-hit still selects one way.
    function automatic logic [WAYS-1:0] lowest_way(input logic [WAYS-1:0] v);
        return v & (~v + WAYS'(1));
    endfunction

endpackage

// File: rtl/icache_refill_ctrl_if.sv
// Fetch, tag-result, SRAM-control and AXI line-read signals of the I-cache controller.
// Optional hit_cnt/miss_cnt exist only when ICACHE_PERF_CNT_EN is defined.
interface icache_refill_ctrl_if;
    import icache_refill_ctrl_pkg::*;

    // Handshakes: a transfer happens on a rising clk where both sides are high
    // (if_valid&if_ready, rd_req&rd_rdy); ret_valid is a push with no backpressure.
    logic                if_valid;
    logic [31:0]         if_addr;
    logic                if_ready;
    logic                data_valid;
    logic [WAYS-1:0]     hit_way;
    logic [31:0]         addr_rbuf;
    logic [INDEX_W-1:0]  mem_index;
    logic [WAYS-1:0]     mem_we;
    logic [WAYS-1:0]     r_way_sel;
    logic                rdata_sel;
    logic [LINE_W-1:0]   r_data_AXI;
    logic                rd_req;
    logic [31:0]         rd_addr;
    logic                rd_rdy;
    logic                ret_valid;
    logic                ret_last;
    logic [BEAT_W-1:0]   ret_data;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;
`endif

    modport master (
        input  if_valid, if_addr, hit_way, rd_rdy, ret_valid, ret_last, ret_data,
        output if_ready, data_valid, addr_rbuf, mem_index, mem_we, r_way_sel,
               rdata_sel, r_data_AXI, rd_req, rd_addr
`ifdef ICACHE_PERF_CNT_EN
        , hit_cnt, miss_cnt
`endif
    );

    modport slave (
        output if_valid, if_addr, hit_way, rd_rdy, ret_valid, ret_last, ret_data,
        input  if_ready, data_valid, addr_rbuf, mem_index, mem_we, r_way_sel,
               rdata_sel, r_data_AXI, rd_req, rd_addr
`ifdef ICACHE_PERF_CNT_EN
        , hit_cnt, miss_cnt
`endif
    );

endinterface

// File: rtl/icache_victim_lfsr.sv
// Free-running 4-bit maximal-length LFSR (x^4+x^3+1); low two bits pick the victim way.
module icache_victim_lfsr
    import icache_refill_ctrl_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    output logic [WAYS-1:0] o_victim
);

    logic [3:0] r_lfsr;

    // Seed is non-zero and the polynomial is maximal, so the register never locks at zero.
    always_ff @(posedge clk) begin
        if (rst) r_lfsr <= HIT0;
        else     r_lfsr <= {r_lfsr[2:0], r_lfsr[3] ^ r_lfsr[2]};
    end

    assign o_victim = WAYS'(1) << r_lfsr[1:0];

endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache main controller: fetch accept, lookup, AXI line refill and victim fill.
// Define ICACHE_PERF_CNT_EN to add saturating hit_cnt/miss_cnt outputs.
module icache_refill_ctrl
    import icache_refill_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    icache_refill_ctrl_if.master bus,
    output state_t              o_state
);

    state_t                r_state, w_next;
    logic [31:0]           r_addr_rbuf;
    logic [WAYS-1:0]       r_victim;
    logic [WAYS-1:0]       w_victim_now;
    logic [BEAT_CNT_W-1:0] r_beat_cnt;
    logic [LINE_W-1:0]     r_line;
    logic                  w_hit;
    logic                  w_accept;

    icache_victim_lfsr u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .o_victim (w_victim_now)
    );

    assign w_hit    = |bus.hit_way;
    assign w_accept = bus.if_valid & bus.if_ready;

    // The SRAM index follows the incoming address on accept so lookup data is ready next cycle.
    assign bus.mem_index  = w_accept ? bus.if_addr[INDEX_MSB:INDEX_LSB]
                                     : r_addr_rbuf[INDEX_MSB:INDEX_LSB];
    assign bus.addr_rbuf  = r_addr_rbuf;
    assign bus.rd_addr    = {r_addr_rbuf[31:OFFSET_W], OFFSET_W'(0)};
    assign bus.r_data_AXI = r_line;
    assign o_state        = r_state;

    always_comb begin
        w_next         = r_state;
        bus.if_ready   = 1'b0;
        bus.data_valid = 1'b0;
        bus.mem_we     = '0;
        bus.r_way_sel  = '0;
        bus.rdata_sel  = 1'b1;
        bus.rd_req     = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.if_ready = 1'b1;
                if (bus.if_valid) w_next = S_LOOKUP;
            end
            S_LOOKUP: begin
                if (w_hit) begin
                    bus.r_way_sel  = lowest_way(bus.hit_way);
                    bus.data_valid = 1'b1;
                    bus.if_ready   = 1'b1;
                    w_next         = bus.if_valid ? S_LOOKUP : S_IDLE;
                end else begin
                    w_next = S_MISS;
                end
            end
            S_MISS: begin
                bus.rd_req = 1'b1;
                if (bus.rd_rdy) w_next = S_REFILL;
            end
            S_REFILL: begin
                if (bus.ret_valid && bus.ret_last) w_next = S_FILL;
            end
            S_FILL: begin
                // Critical word is served straight from the assembled line buffer.
                bus.mem_we     = r_victim;
                bus.r_way_sel  = r_victim;
                bus.rdata_sel  = 1'b0;
                bus.data_valid = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr_rbuf <= '0;
            r_victim    <= '0;
            r_beat_cnt  <= '0;
            r_line      <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) r_addr_rbuf <= bus.if_addr;
            if (r_state == S_LOOKUP && !w_hit) r_victim <= w_victim_now;
            if (r_state == S_MISS && bus.rd_rdy) r_beat_cnt <= '0;
            // Beats outside REFILL are dropped; the counter wraps if a line overruns.
            if (r_state == S_REFILL && bus.ret_valid) begin
                r_line[r_beat_cnt*BEAT_W +: BEAT_W] <= bus.ret_data;
                r_beat_cnt                          <= r_beat_cnt + 1'b1;
            end
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else if (r_state == S_LOOKUP) begin
            if (w_hit) begin
                if (r_hit_cnt != 32'hFFFF_FFFF) r_hit_cnt <= r_hit_cnt + 32'd1;
            end else begin
                if (r_miss_cnt != 32'hFFFF_FFFF) r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign bus.hit_cnt  = r_hit_cnt;
    assign bus.miss_cnt = r_miss_cnt;
`endif

    a_hit_onehot: assert property (@(posedge clk) disable iff (rst)
        (r_state == S_LOOKUP) |-> $onehot0(bus.hit_way));

endmodule
